// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: control NOP word,
// register-zero index, controller state encoding and the output bundle type.
package pipe_hazard_ctrl_pkg;

    localparam logic [12:0] CTRL_NOP = 13'h0001;
    localparam logic [4:0]  REG_ZERO = 5'd0;

    typedef enum logic {
        RUN      = 1'b0,
        MUL_WAIT = 1'b1
    } haz_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_bubble;
        logic ex_mem_bubble;
        logic busy;
    } haz_ctrl_t;

    // Free-flowing pipeline: everything loads, nothing is squashed.
    function automatic haz_ctrl_t ctrl_run_default();
        haz_ctrl_t c;
        c.pc_en         = 1'b1;
        c.if_id_en      = 1'b1;
        c.if_id_flush   = 1'b0;
        c.id_ex_en      = 1'b1;
        c.id_ex_bubble  = 1'b0;
        c.ex_mem_bubble = 1'b0;
        c.busy          = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the ID/EX pipeline fields and the controller.
// master = pipeline side (drives decode info), slave = hazard controller.
interface pipe_hazard_ctrl_if;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       id_uses_rt;
    logic       id_is_mul;
    logic       id_ex_memread;
    logic [4:0] id_ex_rt;
    logic       branch_taken;
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_bubble;
    logic       ex_mem_bubble;
    logic       busy;

    modport master (
        output if_id_rs, if_id_rt, id_uses_rt, id_is_mul,
               id_ex_memread, id_ex_rt, branch_taken,
        input  pc_en, if_id_en, if_id_flush, id_ex_en,
               id_ex_bubble, ex_mem_bubble, busy
    );

    modport slave (
        input  if_id_rs, if_id_rt, id_uses_rt, id_is_mul,
               id_ex_memread, id_ex_rt, branch_taken,
        output pc_en, if_id_en, if_id_flush, id_ex_en,
               id_ex_bubble, ex_mem_bubble, busy
    );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_cmp.sv
// Combinational load-use comparator; shared with the forwarding unit.
import pipe_hazard_ctrl_pkg::*;

module hazard_load_use_cmp (
    input  logic       id_ex_memread,
    input  logic [4:0] id_ex_rt,
    input  logic [4:0] if_id_rs,
    input  logic [4:0] if_id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);

    // A load writing r0 never creates a real dependency.
    always_comb begin
        load_use = id_ex_memread && (id_ex_rt != REG_ZERO) &&
                   ((id_ex_rt == if_id_rs) || (id_uses_rt && (id_ex_rt == if_id_rt)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubble, taken-branch flush and
// multi-cycle multiply stall. Optional perf counters under HAZ_PERF_CNT_EN.
import pipe_hazard_ctrl_pkg::*;

module pipe_hazard_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic                clk,
    input  logic                reset,
`ifdef HAZ_PERF_CNT_EN
    output logic [15:0]         stall_cycles,
    output logic [15:0]         flush_events,
`endif
    pipe_hazard_ctrl_if.slave   hz
);

    localparam int             CW       = $clog2(MUL_LAT) + 1;
    localparam logic [CW-1:0]  MUL_LOAD = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]  CNT_ZERO = CW'(0);

    haz_state_e    state_q, state_d;
    logic [CW-1:0] mul_cnt_q, mul_cnt_d;
    logic          load_use;
    haz_ctrl_t     ctrl;

    hazard_load_use_cmp u_lu_cmp (
        .id_ex_memread (hz.id_ex_memread),
        .id_ex_rt      (hz.id_ex_rt),
        .if_id_rs      (hz.if_id_rs),
        .if_id_rt      (hz.if_id_rt),
        .id_uses_rt    (hz.id_uses_rt),
        .load_use      (load_use)
    );

    // State and multiply countdown registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            mul_cnt_q <= CNT_ZERO;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Next state: a taken branch aborts any multiply wait.
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        if (hz.branch_taken) begin
            state_d   = RUN;
            mul_cnt_d = CNT_ZERO;
        end else begin
            case (state_q)
                RUN: begin
                    if (!load_use && hz.id_is_mul && (MUL_LAT > 1)) begin
                        state_d   = MUL_WAIT;
                        mul_cnt_d = MUL_LOAD;
                    end else begin
                        state_d   = RUN;
                    end
                end
                MUL_WAIT: begin
                    mul_cnt_d = mul_cnt_q - CNT_ONE;
                    if (mul_cnt_q == CNT_ONE) begin
                        state_d = RUN;
                    end else begin
                        state_d = MUL_WAIT;
                    end
                end
                default: begin
                    state_d   = RUN;
                    mul_cnt_d = CNT_ZERO;
                end
            endcase
        end
    end

    // Pipeline register controls; reset forces NOPs into every stage.
    always_comb begin
        ctrl = ctrl_run_default();
        if (!reset) begin
            ctrl.pc_en         = 1'b0;
            ctrl.if_id_en      = 1'b0;
            ctrl.if_id_flush   = 1'b1;
            ctrl.id_ex_en      = 1'b0;
            ctrl.id_ex_bubble  = 1'b1;
            ctrl.ex_mem_bubble = 1'b1;
            ctrl.busy          = 1'b0;
        end else if (hz.branch_taken) begin
            ctrl.if_id_flush   = 1'b1;
            ctrl.id_ex_bubble  = 1'b1;
            ctrl.busy          = (state_q != RUN);
        end else begin
            case (state_q)
                RUN: begin
                    if (load_use) begin
                        ctrl.pc_en        = 1'b0;
                        ctrl.if_id_en     = 1'b0;
                        ctrl.id_ex_bubble = 1'b1;
                    end else begin
                        ctrl.id_ex_bubble = 1'b0;
                    end
                end
                MUL_WAIT: begin
                    ctrl.pc_en         = 1'b0;
                    ctrl.if_id_en      = 1'b0;
                    ctrl.id_ex_en      = 1'b0;
                    ctrl.ex_mem_bubble = (mul_cnt_q != CNT_ONE);
                    ctrl.busy          = 1'b1;
                end
                default: begin
                    ctrl = ctrl_run_default();
                end
            endcase
        end
    end

    assign hz.pc_en         = ctrl.pc_en;
    assign hz.if_id_en      = ctrl.if_id_en;
    assign hz.if_id_flush   = ctrl.if_id_flush;
    assign hz.id_ex_en      = ctrl.id_ex_en;
    assign hz.id_ex_bubble  = ctrl.id_ex_bubble;
    assign hz.ex_mem_bubble = ctrl.ex_mem_bubble;
    assign hz.busy          = ctrl.busy;

`ifdef HAZ_PERF_CNT_EN
    localparam logic [15:0] SAT_MAX = 16'hFFFF;

    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_events_q, flush_events_d;

    // Saturating stall and flush event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cycles_q <= 16'h0000;
            flush_events_q <= 16'h0000;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    // Counter increments, holding at all-ones.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_events_d = flush_events_q;
        if (!ctrl.pc_en && (stall_cycles_q != SAT_MAX)) begin
            stall_cycles_d = stall_cycles_q + 16'h0001;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
        if (hz.branch_taken && (flush_events_q != SAT_MAX)) begin
            flush_events_d = flush_events_q + 16'h0001;
        end else begin
            flush_events_d = flush_events_q;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: MUL_LAT=4 and MUL_LAT=1 controllers driven in lockstep
// against a freeze-cycle reference model. Perf checks under HAZ_PERF_CNT_EN.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic [4:0] rs = 5'd0, rt = 5'd0, exrt = 5'd0;
    logic       uses = 1'b0, mul = 1'b0, mr = 1'b0, br = 1'b0;

    pipe_hazard_ctrl_if hz4();
    pipe_hazard_ctrl_if hz1();

    assign hz4.if_id_rs = rs;      assign hz1.if_id_rs = rs;
    assign hz4.if_id_rt = rt;      assign hz1.if_id_rt = rt;
    assign hz4.id_uses_rt = uses;  assign hz1.id_uses_rt = uses;
    assign hz4.id_is_mul = mul;    assign hz1.id_is_mul = mul;
    assign hz4.id_ex_memread = mr; assign hz1.id_ex_memread = mr;
    assign hz4.id_ex_rt = exrt;    assign hz1.id_ex_rt = exrt;
    assign hz4.branch_taken = br;  assign hz1.branch_taken = br;

`ifdef HAZ_PERF_CNT_EN
    logic [15:0] sc4, fe4, sc1, fe1;
`endif

    pipe_hazard_ctrl #(.MUL_LAT(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
`ifdef HAZ_PERF_CNT_EN
        .stall_cycles (sc4),
        .flush_events (fe4),
`endif
        .hz           (hz4)
    );

    pipe_hazard_ctrl #(.MUL_LAT(1)) dut1 (
        .clk          (clk),
        .reset        (reset),
`ifdef HAZ_PERF_CNT_EN
        .stall_cycles (sc1),
        .flush_events (fe1),
`endif
        .hz           (hz1)
    );

    wire [6:0] obs4 = {hz4.pc_en, hz4.if_id_en, hz4.if_id_flush, hz4.id_ex_en,
                       hz4.id_ex_bubble, hz4.ex_mem_bubble, hz4.busy};
    wire [6:0] obs1 = {hz1.pc_en, hz1.if_id_en, hz1.if_id_flush, hz1.id_ex_en,
                       hz1.id_ex_bubble, hz1.ex_mem_bubble, hz1.busy};

    int checks = 0;
    int errors = 0;
    int lat[2] = '{4, 1};
    int freeze[2] = '{0, 0};
    int sc_m[2] = '{0, 0};
    int fe_m[2] = '{0, 0};
    string nm[7] = '{"busy", "ex_mem_bubble", "id_ex_bubble", "id_ex_en",
                     "if_id_flush", "if_id_en", "pc_en"};

    function automatic logic ref_load_use();
        return mr && (exrt != 5'd0) && ((exrt == rs) || (uses && (exrt == rt)));
    endfunction

    // Expected {pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_bubble,ex_mem_bubble,busy}.
    function automatic logic [6:0] ref_out(int k);
        if (!reset)            return 7'b0010110;
        if (br)                return {5'b11111, 1'b0, freeze[k] > 0};
        if (freeze[k] > 0)     return {5'b00000, freeze[k] > 1, 1'b1};
        if (ref_load_use())    return 7'b0001100;
        return 7'b1101000;
    endfunction

    // ex_mem_bubble is left unchecked when a branch aborts a multiply wait.
    function automatic logic [6:0] ref_mask(int k);
        if (reset && br && (freeze[k] > 0)) return 7'b1111101;
        return 7'b1111111;
    endfunction

    task automatic check_outs(string tag);
        logic [6:0] o, e, m;
        for (int k = 0; k < 2; k++) begin
            o = (k == 0) ? obs4 : obs1;
            e = ref_out(k);
            m = ref_mask(k);
            for (int b = 0; b < 7; b++) begin
                if (m[b]) begin
                    checks++;
                    assert (o[b] === e[b]) else begin
                        errors++;
                        $error("FAIL %s lat%0d %s observed %0b expected %0b",
                               tag, lat[k], nm[b], o[b], e[b]);
                    end
                end
            end
        end
`ifdef HAZ_PERF_CNT_EN
        checks++;
        assert (sc4 === 16'(sc_m[0])) else begin
            errors++; $error("FAIL %s stall_cycles observed %0d expected %0d", tag, sc4, sc_m[0]);
        end
        checks++;
        assert (fe4 === 16'(fe_m[0])) else begin
            errors++; $error("FAIL %s flush_events observed %0d expected %0d", tag, fe4, fe_m[0]);
        end
        checks++;
        assert (sc1 === 16'(sc_m[1])) else begin
            errors++; $error("FAIL %s stall_cycles1 observed %0d expected %0d", tag, sc1, sc_m[1]);
        end
`endif
    endtask

    // Check current cycle, then advance the reference model across the clock edge.
    task automatic step(string tag);
        int nf[2];
        logic [6:0] e;
        #1;
        check_outs(tag);
        for (int k = 0; k < 2; k++) begin
            e = ref_out(k);
            if (!reset)                          nf[k] = 0;
            else if (br)                         nf[k] = 0;
            else if (freeze[k] > 0)              nf[k] = freeze[k] - 1;
            else if (ref_load_use())             nf[k] = 0;
            else if (mul && (lat[k] > 1))        nf[k] = lat[k] - 1;
            else                                 nf[k] = 0;
            if (reset && !e[6] && (sc_m[k] < 65535)) sc_m[k]++;
            if (reset && br && (fe_m[k] < 65535))    fe_m[k]++;
        end
        @(posedge clk);
        freeze = nf;
        #1;
    endtask

    task automatic drive(logic [4:0] a_rs, logic [4:0] a_rt, logic a_uses, logic a_mul,
                         logic a_mr, logic [4:0] a_exrt, logic a_br);
        rs = a_rs; rt = a_rt; uses = a_uses; mul = a_mul;
        mr = a_mr; exrt = a_exrt; br = a_br;
    endtask

    initial begin
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++) step("reset_hold");
        reset = 1'b1;
        step("reset_release");

        drive(5'd5, 5'd1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0);
        step("load_use_rs");
        drive(5'd5, 5'd1, 1'b0, 1'b0, 1'b0, 5'd5, 1'b0);
        step("load_use_after");
        drive(5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0);
        step("load_r0_nostall");
        drive(5'd2, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0);
        step("load_use_rt");
        drive(5'd2, 5'd7, 1'b0, 1'b0, 1'b1, 5'd7, 1'b0);
        step("rt_not_used");

        drive(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        step("mul_issue");
        drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        for (int i = 0; i < 4; i++) step("mul_wait");

        drive(5'd1, 5'd2, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        step("mul_issue2");
        drive(5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        step("mul_wait1");
        br = 1'b1;
        step("branch_in_mul_wait");
        br = 1'b0;
        step("after_branch_abort");

        drive(5'd3, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1);
        step("branch_vs_load_use");

        drive(5'd4, 5'd0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0);
        step("mul_and_load_use");
        drive(5'd4, 5'd0, 1'b0, 1'b1, 1'b0, 5'd4, 1'b0);
        step("mul_after_load_use");
        mul = 1'b0;
        step("mul_wait_b");

        reset = 1'b0;
        step("reset_mid_mul_wait");
        reset = 1'b1;
        step("run_after_async_reset");

        for (int i = 0; i < 600; i++) begin
            drive(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 7) == 0));
            step("random");
        end

`ifdef HAZ_PERF_CNT_EN
        drive(5'd6, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6, 1'b0);
        for (int i = 0; i < 70000; i++) step("stall_saturate");
        checks++;
        assert (sc4 === 16'hFFFF) else begin
            errors++; $error("FAIL stall_sat observed %0h expected ffff", sc4);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
